apb_master_fsm: RTL and testbench

APB_MASTER_FSM -- requirements
Module: apb_master_fsm

---
 rtl/apb_master_fsm_if.sv | 26 ++
 rtl/apb_master_fsm.sv | 215 +++++++++++++++++++++
 tb/tb_apb_master_fsm.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_fsm_if.sv
// APB4 requester/completer signal bundle used by apb_master_fsm.
// Signal names keep the o_/i_ sense of the requester side.
interface apb_master_fsm_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] o_paddr;
  logic          o_psel;
  logic          o_penable;
  logic          o_pwrite;
  logic [DW-1:0] o_pwdata;
  logic [3:0]    o_pstrb;
  logic          i_pready;
  logic          i_pslverr;
  logic [DW-1:0] i_prdata;

  modport master (
    output o_paddr, o_psel, o_penable, o_pwrite, o_pwdata, o_pstrb,
    input  i_pready, i_pslverr, i_prdata
  );

  modport slave (
    input  o_paddr, o_psel, o_penable, o_pwrite, o_pwdata, o_pstrb,
    output i_pready, i_pslverr, i_prdata
  );
endinterface

// File: rtl/apb_master_fsm.sv
// AHB-side to APB4 requester: three-state FSM with one-deep pending slot,
// ACCESS wait timeout and fully registered outputs.
//
// state  | meaning
// IDLE   | no APB cycle; accepts a start or launches a stored pending request
// SETUP  | psel=1, penable=0; address/control presented, wait counter loaded
// ACCESS | psel=1, penable=1; waits for pready or timeout
module apb_master_fsm #(
  parameter int APB_AW  = 32,
  parameter int APB_DW  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               hclk,
  input  logic               rst,
  input  logic               i_start_transfer,
  input  logic [APB_AW-1:0]  i_haddr,
  input  logic [2:0]         i_hsize,
  input  logic               i_hwrite,
  input  logic [APB_DW-1:0]  i_wdata,
  output logic               o_fifo_rd_en,
  apb_master_fsm_if.master   apb,
  output logic [APB_DW-1:0]  o_rdata,
  output logic               o_rdata_valid,
  output logic               o_transfer_done,
  output logic               o_error,
  output logic               o_overrun,
  output logic               o_busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  function automatic logic [3:0] strb_of(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      3'd0:    s = 4'b0001 << a;
      3'd1:    s = 4'b0011 << {a[1], 1'b0};
      3'd2:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic bad_of(input logic [2:0] size, input logic [1:0] a);
    return (size > 3'd2) || (size == 3'd1 && a[0]) || (size == 3'd2 && a != 2'b00);
  endfunction

  state_t state, state_nx;

  logic [CW-1:0]     cnt, cnt_nx;
  logic              pend_vld, pend_vld_nx;
  logic [APB_AW-1:0] pend_addr, pend_addr_nx;
  logic [2:0]        pend_size, pend_size_nx;
  logic              pend_write, pend_write_nx;

  logic [APB_AW-1:0] paddr_q, paddr_nx;
  logic              psel_q, psel_nx;
  logic              penable_q, penable_nx;
  logic              pwrite_q, pwrite_nx;
  logic [APB_DW-1:0] pwdata_q, pwdata_nx;
  logic [3:0]        pstrb_q, pstrb_nx;
  logic              rd_en_q, rd_en_nx;
  logic [APB_DW-1:0] rdata_q, rdata_nx;
  logic              rdv_q, rdv_nx;
  logic              done_q, done_nx;
  logic              err_q, err_nx;
  logic              ovr_q, ovr_nx;
  logic              busy_q, busy_nx;

  logic              complete, tmo, finish;
  logic [APB_AW-1:0] sel_addr;
  logic [2:0]        sel_size;
  logic              sel_write, sel_bad;
  logic              idle_take, take, launch, reject, direct;

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    pend_vld_nx   = pend_vld;
    pend_addr_nx  = pend_addr;
    pend_size_nx  = pend_size;
    pend_write_nx = pend_write;
    paddr_nx      = paddr_q;
    pwrite_nx     = pwrite_q;
    pwdata_nx     = pwdata_q;
    pstrb_nx      = pstrb_q;
    rdata_nx      = rdata_q;

    complete = (state == ACCESS) && apb.i_pready;
    tmo      = (TIMEOUT > 0) && (state == ACCESS) && !apb.i_pready && (cnt == '0);
    finish   = complete || tmo;

    // A stored pending request always has priority over a new start
    sel_addr  = pend_vld ? pend_addr  : i_haddr;
    sel_size  = pend_vld ? pend_size  : i_hsize;
    sel_write = pend_vld ? pend_write : i_hwrite;
    sel_bad   = bad_of(sel_size, sel_addr[1:0]);

    idle_take = (state == IDLE) && (pend_vld || i_start_transfer);
    // An illegal pending request is not chained; it is rejected from IDLE
    // so its error pulse stays separate from the current done pulse.
    take      = idle_take || (finish && pend_vld && !sel_bad);
    launch    = take && !sel_bad;
    reject    = idle_take && sel_bad;
    direct    = (state == IDLE) && !pend_vld && i_start_transfer;

    case (state)
      IDLE:    if (launch) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (finish) state_nx = launch ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase

    if (pend_vld && take) pend_vld_nx = 1'b0;
    ovr_nx = 1'b0;
    if (i_start_transfer && !direct) begin
      if (pend_vld) begin
        ovr_nx = 1'b1;
      end else begin
        pend_vld_nx   = 1'b1;
        pend_addr_nx  = i_haddr;
        pend_size_nx  = i_hsize;
        pend_write_nx = i_hwrite;
      end
    end

    // FIFO head is sampled at the launch edge; the pop follows one cycle later
    rd_en_nx = launch && sel_write;
    if (launch) begin
      paddr_nx  = sel_addr;
      pwrite_nx = sel_write;
      pstrb_nx  = sel_write ? strb_of(sel_size, sel_addr[1:0]) : 4'b0000;
      if (sel_write) pwdata_nx = i_wdata;
    end

    if (state_nx == SETUP)
      cnt_nx = TC_LOAD;
    else if ((state == ACCESS) && !apb.i_pready && (cnt != '0))
      cnt_nx = cnt - 1'b1;

    psel_nx    = (state_nx != IDLE);
    penable_nx = (state_nx == ACCESS);
    done_nx    = finish || reject;
    err_nx     = tmo || (complete && apb.i_pslverr) || reject;
    rdv_nx     = complete && !pwrite_q && !apb.i_pslverr;
    if (rdv_nx) rdata_nx = apb.i_prdata;
    busy_nx    = (state_nx != IDLE) || pend_vld_nx;
  end

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      pend_size  <= '0;
      pend_write <= 1'b0;
      paddr_q    <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      rd_en_q    <= 1'b0;
      rdata_q    <= '0;
      rdv_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      pend_vld   <= pend_vld_nx;
      pend_addr  <= pend_addr_nx;
      pend_size  <= pend_size_nx;
      pend_write <= pend_write_nx;
      paddr_q    <= paddr_nx;
      psel_q     <= psel_nx;
      penable_q  <= penable_nx;
      pwrite_q   <= pwrite_nx;
      pwdata_q   <= pwdata_nx;
      pstrb_q    <= pstrb_nx;
      rd_en_q    <= rd_en_nx;
      rdata_q    <= rdata_nx;
      rdv_q      <= rdv_nx;
      done_q     <= done_nx;
      err_q      <= err_nx;
      ovr_q      <= ovr_nx;
      busy_q     <= busy_nx;
    end
  end

  assign apb.o_paddr   = paddr_q;
  assign apb.o_psel    = psel_q;
  assign apb.o_penable = penable_q;
  assign apb.o_pwrite  = pwrite_q;
  assign apb.o_pwdata  = pwdata_q;
  assign apb.o_pstrb   = pstrb_q;

  assign o_fifo_rd_en    = rd_en_q;
  assign o_rdata         = rdata_q;
  assign o_rdata_valid   = rdv_q;
  assign o_transfer_done = done_q;
  assign o_error         = err_q;
  assign o_overrun       = ovr_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm with hand-computed expectations.
module tb_apb_master_fsm;
  logic        hclk = 1'b0;
  logic        rst  = 1'b1;
  logic        start = 1'b0;
  logic [31:0] haddr = '0;
  logic [2:0]  hsize = '0;
  logic        hwrite = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd_en;
  logic [31:0] rdata;
  logic        rdata_valid, done, error, overrun, busy;
  int          total = 0;
  int          bad = 0;
  int          n;

  always #5 hclk = ~hclk;

  apb_master_fsm_if #(.AW(32), .DW(32)) apb ();

  apb_master_fsm #(.APB_AW(32), .APB_DW(32), .TIMEOUT(16)) dut (
    .hclk(hclk), .rst(rst), .i_start_transfer(start), .i_haddr(haddr),
    .i_hsize(hsize), .i_hwrite(hwrite), .i_wdata(wdata), .o_fifo_rd_en(rd_en),
    .apb(apb), .o_rdata(rdata), .o_rdata_valid(rdata_valid),
    .o_transfer_done(done), .o_error(error), .o_overrun(overrun), .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [2:0] s, input logic w, input logic [31:0] d);
    start  = 1'b1;
    haddr  = a;
    hsize  = s;
    hwrite = w;
    wdata  = d;
  endtask

  initial begin
    apb.i_pready  = 1'b0;
    apb.i_pslverr = 1'b0;
    apb.i_prdata  = '0;
    #12;
    chk("rst_psel", apb.o_psel, 0);
    chk("rst_penable", apb.o_penable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    chk("rst_rden", rd_en, 0);

    // halfword write, accepted on the first edge after reset release
    rst = 1'b0;
    apb.i_pready = 1'b1;
    req(32'h1002, 3'd1, 1'b1, 32'hAABBCCDD);
    step(); start = 1'b0;
    chk("wr_setup_psel", apb.o_psel, 1);
    chk("wr_setup_pen", apb.o_penable, 0);
    chk("wr_paddr", apb.o_paddr, 32'h1002);
    chk("wr_pwrite", apb.o_pwrite, 1);
    chk("wr_pstrb", apb.o_pstrb, 4'b1100);
    chk("wr_pwdata", apb.o_pwdata, 32'hAABBCCDD);
    chk("wr_rden", rd_en, 1);
    chk("wr_busy", busy, 1);
    step();
    chk("wr_acc_pen", apb.o_penable, 1);
    chk("wr_acc_rden", rd_en, 0);
    chk("wr_acc_done", done, 0);
    step();
    chk("wr_done", done, 1);
    chk("wr_err", error, 0);
    chk("wr_end_psel", apb.o_psel, 0);
    chk("wr_end_pen", apb.o_penable, 0);
    chk("wr_end_rdv", rdata_valid, 0);
    step();
    chk("wr_done_clr", done, 0);
    chk("wr_idle_busy", busy, 0);

    // word read with three wait cycles
    apb.i_pready = 1'b0;
    req(32'h2000, 3'd2, 1'b0, 32'h0);
    step(); start = 1'b0;
    chk("rd_pstrb", apb.o_pstrb, 4'b0000);
    chk("rd_rden", rd_en, 0);
    step(); step(); step(); step();
    chk("rd_wait_pen", apb.o_penable, 1);
    chk("rd_wait_done", done, 0);
    apb.i_pready = 1'b1;
    apb.i_prdata = 32'h12345678;
    step();
    chk("rd_done", done, 1);
    chk("rd_rdv", rdata_valid, 1);
    chk("rd_rdata", rdata, 32'h12345678);
    chk("rd_err", error, 0);
    chk("rd_end_psel", apb.o_psel, 0);

    // read answered with pslverr leaves o_rdata untouched
    apb.i_pslverr = 1'b1;
    apb.i_prdata  = 32'hDEADBEEF;
    req(32'h3000, 3'd2, 1'b0, 32'h0);
    step(); start = 1'b0;
    step(); step();
    chk("slv_done", done, 1);
    chk("slv_err", error, 1);
    chk("slv_rdv", rdata_valid, 0);
    chk("slv_rdata", rdata, 32'h12345678);
    apb.i_pslverr = 1'b0;

    // illegal size
    req(32'h4000, 3'd3, 1'b1, 32'h0);
    step(); start = 1'b0;
    chk("ill3_done", done, 1);
    chk("ill3_err", error, 1);
    chk("ill3_psel", apb.o_psel, 0);
    chk("ill3_rden", rd_en, 0);
    step();
    chk("ill3_psel2", apb.o_psel, 0);

    // misaligned halfword
    req(32'h0041, 3'd1, 1'b1, 32'h0);
    step(); start = 1'b0;
    chk("ill1_err", error, 1);
    chk("ill1_psel", apb.o_psel, 0);

    // byte write on lane 3
    req(32'h5003, 3'd0, 1'b1, 32'h00000055);
    step(); start = 1'b0;
    chk("byte_pstrb", apb.o_pstrb, 4'b1000);
    step(); step();
    chk("byte_done", done, 1);
    chk("byte_err", error, 0);

    // timeout after 16 ACCESS cycles
    apb.i_pready = 1'b0;
    req(32'h6000, 3'd2, 1'b0, 32'h0);
    step(); start = 1'b0;
    chk("tmo_setup_pen", apb.o_penable, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (apb.o_penable) n++;
      else break;
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_psel", apb.o_psel, 0);
    chk("tmo_done", done, 1);
    chk("tmo_err", error, 1);
    chk("tmo_rdv", rdata_valid, 0);

    // back-to-back: second chains without idle, third overruns
    apb.i_pready = 1'b1;
    apb.i_prdata = 32'hCAFEF00D;
    req(32'h0100, 3'd2, 1'b1, 32'h11111111);
    step();
    chk("b2b_a_pwdata", apb.o_pwdata, 32'h11111111);
    chk("b2b_a_rden", rd_en, 1);
    req(32'h0200, 3'd2, 1'b0, 32'h0);
    step();
    chk("b2b_a_pen", apb.o_penable, 1);
    req(32'h0300, 3'd2, 1'b0, 32'h0);
    step(); start = 1'b0;
    chk("b2b_a_done", done, 1);
    chk("b2b_b_psel", apb.o_psel, 1);
    chk("b2b_b_pen", apb.o_penable, 0);
    chk("b2b_b_paddr", apb.o_paddr, 32'h0200);
    chk("b2b_b_pwrite", apb.o_pwrite, 0);
    chk("b2b_ovr", overrun, 1);
    step();
    chk("b2b_ovr_clr", overrun, 0);
    chk("b2b_b_acc", apb.o_penable, 1);
    step();
    chk("b2b_b_done", done, 1);
    chk("b2b_b_rdata", rdata, 32'hCAFEF00D);
    chk("b2b_b_rdv", rdata_valid, 1);
    step();
    chk("b2b_end_psel", apb.o_psel, 0);
    chk("b2b_end_busy", busy, 0);

    // reset asserted mid-ACCESS
    apb.i_pready = 1'b0;
    req(32'h7000, 3'd2, 1'b0, 32'h0);
    step(); start = 1'b0;
    step();
    chk("rsta_pre_pen", apb.o_penable, 1);
    #2 rst = 1'b1;
    #1;
    chk("rsta_psel", apb.o_psel, 0);
    chk("rsta_pen", apb.o_penable, 0);
    chk("rsta_busy", busy, 0);
    chk("rsta_done", done, 0);
    chk("rsta_rdata", rdata, 0);
    rst = 1'b0;
    apb.i_pready = 1'b1;
    req(32'h8000, 3'd2, 1'b0, 32'h0);
    step(); start = 1'b0;
    chk("post_rst_psel", apb.o_psel, 1);
    chk("post_rst_pen", apb.o_penable, 0);
    chk("post_rst_paddr", apb.o_paddr, 32'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
